// File: rtl/joy_serial_rd_pkg.sv
// Shared definitions for the serial gamepad reader.
//   KEMP_* : bit positions inside the active-high Kempston joystick byte.
//   joy_state_t : scan sequencer states.
package joy_serial_rd_pkg;

    localparam int unsigned KEMP_RIGHT = 0;
    localparam int unsigned KEMP_LEFT  = 1;
    localparam int unsigned KEMP_DOWN  = 2;
    localparam int unsigned KEMP_UP    = 3;
    localparam int unsigned KEMP_FIRE  = 4;
    localparam int unsigned KEMP_FIRE2 = 5;
    localparam int unsigned KEMP_FIRE3 = 6;
    localparam int unsigned KEMP_START = 7;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        CLK_HI,
        CLK_LO,
        DONE
    } joy_state_t;

endpackage

// File: rtl/joy_serial_rd_sync2.sv
// sync2: generic two-flop synchronizer for a single asynchronous input.
//   clk     : destination clock
//   rst_n   : asynchronous active-low reset, both flops load RST_VAL
//   d       : asynchronous input
//   q       : synchronized output (two clk cycles of latency)
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/joy_serial_rd.sv
// joy_serial_rd: polls an SNES-style serial gamepad and produces the
// active-high Kempston joystick byte. The byte is committed once per
// complete scan so readers never see a partially shifted value.
//
// Ports:
//   rst_n         : asynchronous active-low reset
//   clk28         : system clock
//   joy_data      : pad serial data, active-low, asynchronous
//   joy_latch     : pad parallel-load strobe, active-high
//   joy_clk       : pad shift clock, idles high
//   kempston_data : [0]R [1]L [2]Dn [3]Up [4]B [5]A [6]Y [7]Start, 1 = pressed
//   scan_done     : one-cycle pulse when kempston_data is updated
//
// Build option: define JOY_TURBO_EN to make X (scan bit 9) a turbo fire
// button that toggles kempston_data[4] every 4th scan while held.
module joy_serial_rd
    import joy_serial_rd_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 168,
    parameter int unsigned BITS        = 16,
    parameter int unsigned POLL_CYCLES = 28000
) (
    input  logic       rst_n,
    input  logic       clk28,
    input  logic       joy_data,
    output logic       joy_latch,
    output logic       joy_clk,
    output logic [7:0] kempston_data,
    output logic       scan_done
);

    localparam int unsigned PT_W  = $clog2(POLL_CYCLES);
    localparam int unsigned HT_W  = $clog2(2 * HALF_PERIOD);
    localparam int unsigned IDX_W = $clog2(BITS);

    localparam logic [PT_W-1:0]  POLL_LAST  = PT_W'(POLL_CYCLES - 1);
    localparam logic [HT_W-1:0]  LATCH_LAST = HT_W'(2 * HALF_PERIOD - 1);
    localparam logic [HT_W-1:0]  HP_LAST    = HT_W'(HALF_PERIOD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(BITS - 1);

    joy_state_t       state, state_d;
    logic [PT_W-1:0]  poll_cnt;
    logic [HT_W-1:0]  ht_cnt;
    logic [IDX_W-1:0] bit_idx;
    logic [BITS-1:0]  shreg;
    logic             data_sync;
    logic             poll_pending;
    logic             start_req;
    logic [7:0]       scan_kemp;
    logic             turbo_fire;
    logic             unused_bits;

    sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk28),
        .rst_n (rst_n),
        .d     (joy_data),
        .q     (data_sync)
    );

    // Free-running poll period timer.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            poll_cnt <= '0;
        end else if (poll_cnt == POLL_LAST) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + 1'b1;
        end
    end

    // A wrap that lands mid-scan is remembered so the next scan starts
    // right after DONE instead of waiting a whole extra poll period.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            poll_pending <= 1'b0;
        end else if (state == IDLE) begin
            poll_pending <= 1'b0;
        end else if (poll_cnt == '0) begin
            poll_pending <= 1'b1;
        end
    end

    assign start_req = (poll_cnt == '0) || poll_pending;

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        joy_latch = 1'b0;
        joy_clk   = 1'b1;
        case (state)
            IDLE: begin
                if (start_req) state_d = LATCH;
            end
            LATCH: begin
                joy_latch = 1'b1;
                if (ht_cnt == LATCH_LAST) state_d = CLK_HI;
            end
            CLK_HI: begin
                if (ht_cnt == HP_LAST) state_d = CLK_LO;
            end
            CLK_LO: begin
                joy_clk = 1'b0;
                if (ht_cnt == HP_LAST) state_d = (bit_idx == IDX_LAST) ? DONE : CLK_HI;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Phase timer restarts on every state change.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            ht_cnt <= '0;
        end else if (state_d != state) begin
            ht_cnt <= '0;
        end else if (state inside {LATCH, CLK_HI, CLK_LO}) begin
            ht_cnt <= ht_cnt + 1'b1;
        end else begin
            ht_cnt <= '0;
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx <= '0;
        end else if (state == LATCH) begin
            bit_idx <= '0;
        end else if (state == CLK_LO && ht_cnt == HP_LAST && bit_idx != IDX_LAST) begin
            bit_idx <= bit_idx + 1'b1;
        end
    end

    // Sample just before joy_clk falls, when the pad output has settled
    // for a full half-period after the previous rising edge.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '1;
        end else if (state == CLK_HI && ht_cnt == HP_LAST) begin
            shreg[bit_idx] <= ~data_sync;
        end
    end

`ifdef JOY_TURBO_EN
    logic [2:0] turbo_cnt;

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            turbo_cnt <= '0;
        end else if (state == DONE) begin
            turbo_cnt <= shreg[9] ? turbo_cnt + 1'b1 : '0;
        end
    end

    assign turbo_fire  = shreg[9] & turbo_cnt[2];
    assign unused_bits = ^{shreg[BITS-1:10], shreg[2]};
`else
    assign turbo_fire  = 1'b0;
    assign unused_bits = ^{shreg[BITS-1:9], shreg[2]};
`endif

    always_comb begin
        scan_kemp             = '0;
        scan_kemp[KEMP_RIGHT] = shreg[7];
        scan_kemp[KEMP_LEFT]  = shreg[6];
        scan_kemp[KEMP_DOWN]  = shreg[5];
        scan_kemp[KEMP_UP]    = shreg[4];
        scan_kemp[KEMP_FIRE]  = shreg[0] | turbo_fire;
        scan_kemp[KEMP_FIRE2] = shreg[8];
        scan_kemp[KEMP_FIRE3] = shreg[1];
        scan_kemp[KEMP_START] = shreg[3];
        if (scan_kemp[KEMP_RIGHT] && scan_kemp[KEMP_LEFT]) begin
            scan_kemp[KEMP_RIGHT] = 1'b0;
            scan_kemp[KEMP_LEFT]  = 1'b0;
        end
        if (scan_kemp[KEMP_UP] && scan_kemp[KEMP_DOWN]) begin
            scan_kemp[KEMP_UP]   = 1'b0;
            scan_kemp[KEMP_DOWN] = 1'b0;
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            kempston_data <= '0;
            scan_done     <= 1'b0;
        end else begin
            scan_done <= (state == DONE);
            if (state == DONE) kempston_data <= scan_kemp;
        end
    end

endmodule

// File: tb/tb_joy_serial_rd.sv
module tb_joy_serial_rd;

    localparam int unsigned HP        = 8;
    localparam int unsigned NB        = 16;
    localparam int unsigned POLL      = 400;
    localparam int unsigned FAST_POLL = 100;
    // Posedges from reset release to scan_done visible: the first posedge is
    // the timer==0 cycle, followed by the (2+2*BITS)*HALF_PERIOD+1 latency.
    localparam int unsigned LAT       = (2 + 2 * NB) * HP + 1;

    logic       clk28 = 1'b0;
    logic       rst_n = 1'b0;
    logic       joy_data, joy_latch, joy_clk, scan_done;
    logic [7:0] kempston_data;
    logic       f_latch, f_clk, f_done;
    logic [7:0] f_kemp;

    always #5 clk28 = ~clk28;

    joy_serial_rd #(.HALF_PERIOD(HP), .BITS(NB), .POLL_CYCLES(POLL)) u_dut (
        .rst_n         (rst_n),
        .clk28         (clk28),
        .joy_data      (joy_data),
        .joy_latch     (joy_latch),
        .joy_clk       (joy_clk),
        .kempston_data (kempston_data),
        .scan_done     (scan_done)
    );

    // Poll period shorter than a scan: scans must run back-to-back.
    joy_serial_rd #(.HALF_PERIOD(HP), .BITS(NB), .POLL_CYCLES(FAST_POLL)) u_fast (
        .rst_n         (rst_n),
        .clk28         (clk28),
        .joy_data      (joy_data),
        .joy_latch     (f_latch),
        .joy_clk       (f_clk),
        .kempston_data (f_kemp),
        .scan_done     (f_done)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Pad model: buttons bit n = scan position n, 1 = pressed. The data line
    // shows the live button at the current shift position.
    logic [15:0] btn = '0;
    logic        pad_connected = 1'b0;
    int          pad_pos = 0;
    logic        clk_q = 1'b1;

    always @(posedge clk28) begin
        clk_q <= joy_clk;
        if (joy_latch) pad_pos <= 0;
        else if (joy_clk && !clk_q) pad_pos <= pad_pos + 1;
    end

    assign joy_data = !pad_connected ? 1'b1 :
                      (pad_pos < 16) ? ~btn[pad_pos[3:0]] : 1'b1;

    int cyc;
    always @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else cyc <= cyc + 1;
    end

    // Waveform monitors.
    int latch_run = 0, last_latch = 0, lo_run = 0, lo_pulses = 0, bad_lo = 0;
    int glitch_cnt = 0;
    logic [7:0] last_k = '0;
    int fast_t[$];

    always @(negedge clk28) begin
        if (joy_latch) begin
            latch_run++;
            lo_pulses = 0;
            bad_lo    = 0;
            lo_run    = 0;
        end else begin
            if (latch_run != 0) begin
                last_latch = latch_run;
                latch_run  = 0;
            end
            if (!joy_clk) lo_run++;
            else if (lo_run != 0) begin
                lo_pulses++;
                if (lo_run != HP) bad_lo++;
                lo_run = 0;
            end
        end
        if (rst_n && !scan_done && kempston_data !== last_k) glitch_cnt++;
        last_k = kempston_data;
        if (f_done === 1'b1) fast_t.push_back(cyc);
    end

    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 2 * POLL && !seen; i++) begin
            @(negedge clk28);
            if (scan_done === 1'b1) seen = 1'b1;
        end
        check({tag, "_seen"}, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_pos(input int pos);
        bit seen = 1'b0;
        for (int i = 0; i < 2 * POLL && !seen; i++) begin
            @(negedge clk28);
            if (pad_pos == pos && !joy_latch) seen = 1'b1;
        end
        check("pad_pos_reached", {31'd0, seen}, 32'd1);
    endtask

    task automatic check_scan(input string tag);
        logic [7:0] e;
        wait_done(tag);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        check(tag, {24'd0, kempston_data}, {24'd0, e});
        check({tag, "_glitch"}, glitch_cnt, 0);
    endtask

    int t0;

    initial begin
        repeat (3) @(negedge clk28);
        check("rst_latch", {31'd0, joy_latch}, 32'd0);
        check("rst_clk",   {31'd0, joy_clk},   32'd1);
        check("rst_kemp",  {24'd0, kempston_data}, 32'h00);
        check("rst_done",  {31'd0, scan_done}, 32'd0);
        rst_n = 1'b1;

        // No pad: pull-up reads nothing pressed.
        exp_q.push_back(8'h00);
        check_scan("nopad0");
        check("first_latency", cyc, LAT + 1);
        t0 = cyc;
        exp_q.push_back(8'h00);
        check_scan("nopad1");
        check("period1", cyc - t0, POLL);
        t0 = cyc;
        exp_q.push_back(8'h00);
        check_scan("nopad2");
        check("period2", cyc - t0, POLL);

        // B + Up.
        pad_connected = 1'b1;
        btn = 16'h0011;
        exp_q.push_back(8'h18);
        check_scan("b_up");
        check("latch_len", last_latch, 2 * HP);
        check("clk_lo_pulses", lo_pulses, NB);
        check("clk_lo_width_bad", bad_lo, 0);

        // Left + Right + A: directions cancel.
        btn = 16'h01C0;
        exp_q.push_back(8'h20);
        check_scan("lr_a");

        // Up + Down + Right: vertical cancels, right stays.
        btn = 16'h00B0;
        exp_q.push_back(8'h01);
        check_scan("ud_r");

        // Mid-scan change after bit 4: bits 0..4 from Start+Right,
        // bits 5.. from B+Y+Left -> Start and Left.
        btn = 16'h0088;
        wait_pos(5);
        btn = 16'h0043;
        check("hold_mid", {24'd0, kempston_data}, 32'h01);
        exp_q.push_back(8'h82);
        check_scan("midchg");

        exp_q.push_back(8'h52);
        check_scan("b_y_l");

        // Reset in the middle of bit 9.
        btn = 16'h0010;
        wait_pos(9);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_clk",   {31'd0, joy_clk},   32'd1);
        check("midrst_latch", {31'd0, joy_latch}, 32'd0);
        check("midrst_kemp",  {24'd0, kempston_data}, 32'h00);
        check("midrst_done",  {31'd0, scan_done}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk28);
        rst_n = 1'b1;
        exp_q.push_back(8'h08);
        check_scan("post_rst");
        check("rst_latency", cyc, LAT + 1);

`ifdef JOY_TURBO_EN
        btn = 16'h0200;
        for (int s = 0; s < 8; s++) begin
            exp_q.push_back((s >= 4) ? 8'h10 : 8'h00);
            check_scan("turbo");
        end
        btn = 16'h0000;
        exp_q.push_back(8'h00);
        check_scan("turbo_rel");
`else
        btn = 16'h0200;
        exp_q.push_back(8'h00);
        check_scan("x_ignored");
`endif

        check("fast_count", {31'd0, (fast_t.size() >= 2)}, 32'd1);
        if (fast_t.size() >= 2) begin
            check("fast_first", fast_t[0], LAT + 1);
            check("fast_gap", fast_t[1] - fast_t[0], LAT + 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/joy_serial_rd.md
Name: joy_serial_rd

Overview:
- Upstream feeder of the I/O port decoder: polls an SNES-style serial gamepad (latch/clock/data shift-register pad) and produces the 8-bit active-high Kempston joystick byte consumed by the Kempston read path and the Sinclair-key overlay.
- Runs entirely in the clk28 domain.
- The output byte is updated atomically once per complete scan, so the CPU never sees a partially shifted value.

Parameters:
- HALF_PERIOD, 168: clk28 cycles per joy_clk half-period (6 us at 28 MHz).
- BITS, 16: bits shifted per scan (12 buttons plus 4 fixed-high bits).
- POLL_CYCLES, 28000: scan start-to-start period (1 ms). Must exceed (2+2*BITS)*HALF_PERIOD, otherwise scans run back-to-back.

Ports:
- rst_n  input  1  asynchronous active-low reset
- clk28  input  1  system clock
- joy_data  input  1  pad serial data, active-low (0 = pressed), asynchronous, external pull-up
- joy_latch  output  1  pad parallel-load strobe, active-high
- joy_clk  output  1  pad shift clock, idles high
- kempston_data  output  8  [0]right [1]left [2]down [3]up [4]fire(B) [5]fire2(A) [6]fire3(Y) [7]start; 1 = pressed
- scan_done  output  1  one-cycle pulse when kempston_data is updated

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk28.
- Reset values:
  - joy_latch=0, joy_clk=1, kempston_data=8'h00, scan_done=0.
  - FSM=IDLE; poll timer and half-period timer = 0; shift register = all ones.
- joy_data passes through a 2-flop synchronizer, reset to 1.
- A poll timer counts 0..POLL_CYCLES-1 and wraps continuously. A scan starts when the timer is 0 and the FSM is in IDLE.
- FSM:
  - IDLE: joy_latch=0, joy_clk=1.
  - LATCH: joy_latch=1 for 2*HALF_PERIOD cycles, then go to CLK_HI with bit index 0.
  - CLK_HI: joy_clk=1 for HALF_PERIOD cycles. On the last cycle, sample the synchronized data inverted into shift register position [index].
  - CLK_LO: joy_clk=0 for HALF_PERIOD cycles. At the end, if index==BITS-1 go to DONE; else increment index and go to CLK_HI. The rising edge of joy_clk shifts the pad.
  - DONE: one cycle. Load kempston_data from the shift register, pulse scan_done, go to IDLE.
- Scan latency: from timer==0 to the scan_done pulse is (2+2*BITS)*HALF_PERIOD + 1 cycles. For the defaults this is 5713.
- Bit mapping, in scan order B,Y,Sel,St,Up,Dn,L,R,A,X,L,R,-,-,-,-:
  - [0]=R(bit7), [1]=L(bit6), [2]=Dn(bit5), [3]=Up(bit4)
  - [4]=B(bit0), [5]=A(bit8), [6]=Y(bit1), [7]=St(bit3)
- Opposite-direction rule: if both left and right read pressed, clear both [1:0]. Apply the same rule to up and down [3:2].
- Disconnected pad: the pull-up reads all ones, i.e. nothing pressed, so kempston_data=8'h00. No fault indication.
- The timer wraps to 0 while a scan is in progress (POLL_CYCLES too small): the request is held and the next scan starts in the cycle after DONE.
- Reset asserted mid-scan: outputs return immediately to their reset values. The pad is re-latched on the first scan after reset; a partial scan is never committed.
- Bit index width is $clog2(BITS). Timer widths are $clog2 of their terminal counts; counters never overflow.

Optional Feature:
- Macro JOY_TURBO_EN.
  - Defined: the X button (bit9) acts as turbo fire. While X is held, kempston_data[4] toggles on every 4th scan_done, giving about 125 Hz at defaults. The toggle is OR-ed with B, and the turbo phase counter resets when X is released.
  - Not defined: X is ignored and kempston_data[4] follows B only.

Decomposition:
- Shared common package:
  - kempston bit-index constants (KEMP_RIGHT..KEMP_START)
  - enum typedef joy_state_t {IDLE, LATCH, CLK_HI, CLK_LO, DONE}
- One sub-module, sync2: a generic 2-flop synchronizer with parameterized reset value, reusable for tape_in.

Test Plan:
- Pad model drives all ones (no pad); run 3 scans -> kempston_data=8'h00, scan_done pulses exactly POLL_CYCLES apart, first at cycle 5713 after reset.
- Pad holds B and Up pressed -> after the next scan_done, kempston_data=8'h18. joy_latch is high for exactly 336 cycles and joy_clk shows 16 low pulses of 168 cycles each.
- Pad holds Left+Right+A -> kempston_data=8'h20, with the opposite directions cancelled.
- Change buttons mid-scan, after bit 4 has been shifted -> kempston_data is unchanged until scan_done, then reflects the sampled bits only; no glitch between updates.
- Assert rst_n low at bit 9 of a scan -> joy_clk=1, joy_latch=0, kempston_data=8'h00 asynchronously. After release, the first scan completes at cycle 5713.
- With JOY_TURBO_EN, hold X only -> bit4 toggles every 4 scans (pattern 0,0,0,0,1,1,1,1...). Release X -> bit4=0 on the next scan_done.
